// File: rtl/axi_master_rd.sv
// AXI read-channel master: one outstanding burst, R beats streamed combinationally
// to a local consumer, with a done pulse carrying worst response and r_last framing error.
module axi_master_rd #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 8,
  parameter int SIZE_BITS = 3
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [LEN_BITS-1:0]  cmd_len,
  input  logic [SIZE_BITS-1:0] cmd_size,
  input  logic [1:0]           cmd_burst,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_BITS-1:0] ar_addr,
  output logic [LEN_BITS-1:0]  ar_len,
  output logic [SIZE_BITS-1:0] ar_size,
  output logic [1:0]           ar_burst,
  output logic [3:0]           ar_cache,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [DATA_BITS-1:0] r_data,
  input  logic                 r_last,
  input  logic [1:0]           r_resp,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_last,
  output logic                 done,
  output logic [1:0]           done_resp,
  output logic                 done_last_err
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // ADDR  | AR presented with registered fields until ar_ready
  // DATA  | R beats passed through until the terminating beat
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DONE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [SIZE_BITS-1:0] size_q, size_d;
  logic [1:0]           burst_q, burst_d;
  logic [LEN_BITS-1:0]  cnt_q, cnt_d;
  logic [1:0]           resp_q, resp_d;
  logic                 err_q, err_d;

  logic in_data, beat, at_len, term;

  assign in_data = (state_q == ST_DATA);
  assign beat    = in_data & r_valid & rd_ready;
  assign at_len  = (cnt_q == len_q);
  // Burst ends on the counted last beat or on an early r_last, whichever comes first.
  assign term    = beat & (r_last | at_len);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          size_d  = cmd_size;
          burst_d = cmd_burst;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ar_ready) begin
          cnt_d   = '0;
          resp_d  = '0;
          err_d   = 1'b0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (r_resp > resp_q) resp_d = r_resp;
          if (term) begin
            // r_last disagreeing with the counted last beat is a framing error either way
            err_d   = r_last ^ at_len;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready     = (state_q == ST_IDLE) & ~areset;
  assign ar_valid      = (state_q == ST_ADDR);
  assign ar_addr       = addr_q;
  assign ar_len        = len_q;
  assign ar_size       = size_q;
  assign ar_burst      = burst_q;
  assign ar_cache      = 4'b0000;
  assign r_ready       = in_data & rd_ready;
  assign rd_valid      = in_data & r_valid;
  assign rd_data       = in_data ? r_data : '0;
  assign rd_last       = in_data & r_valid & (r_last | at_len);
  assign done          = (state_q == ST_DONE);
  assign done_resp     = resp_q;
  assign done_last_err = err_q;

endmodule

// File: tb/tb_axi_master_rd.sv
// Directed bench for axi_master_rd: a slave model feeds R beats, and a burst-level
// model predicts delivered beats, rd_last, done timing and the done report.
module tb_axi_master_rd;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic [1:0]  cmd_burst = '0;
  logic        ar_valid, ar_ready = 1'b0;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic [3:0]  ar_cache;
  logic        r_valid = 1'b0, r_ready;
  logic [31:0] r_data = '0;
  logic        r_last = 1'b0;
  logic [1:0]  r_resp = '0;
  logic        rd_valid, rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic        rd_last, done;
  logic [1:0]  done_resp;
  logic        done_last_err;

  always #5 aclk = ~aclk;

  axi_master_rd dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst), .ar_cache(ar_cache),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last), .r_resp(r_resp),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_resp(done_resp), .done_last_err(done_last_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // slave beat table and burst-level expectations
  logic [31:0] sl_data[16];
  logic [1:0]  sl_resp[16];
  logic        sl_last[16];
  logic [31:0] exp_data_q[$];
  logic        exp_last_q[$];
  logic [1:0]  m_resp;
  logic        m_err;
  logic [31:0] e_addr;
  logic [7:0]  e_len;
  logic [2:0]  e_size;
  logic [1:0]  e_burst;
  bit          done_pending = 0, ar_pending = 0, done_prev = 0, chk_en = 0;
  int          last_beat_cyc = 0, delivered = 0;
  logic [31:0] last_rd_data = '0;
  logic [1:0]  prev_resp = '0;
  logic        prev_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Delivered beats run up to the first r_last or beat len, whichever comes first.
  function automatic void build_model(input int len, input int n);
    bit early, missing;
    exp_data_q.delete();
    exp_last_q.delete();
    m_resp = 2'd0;
    m_err  = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_data_q.push_back(sl_data[i]);
      exp_last_q.push_back(sl_last[i] || (i == len));
      if (sl_resp[i] > m_resp) m_resp = sl_resp[i];
      if (sl_last[i] || (i == len)) begin
        early   = sl_last[i] && (i < len);
        missing = !sl_last[i] && (i == len);
        m_err   = early || missing;
        break;
      end
    end
  endfunction

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // compare process
  initial forever begin
    logic [31:0] ed;
    logic        el;
    @(negedge aclk);
    if (chk_en && !areset) begin
      if (ar_pending) check("ar_valid_held", ar_valid, 1);
      if (ar_valid) begin
        check("ar_addr", ar_addr, e_addr);
        check("ar_len", ar_len, e_len);
        check("ar_size", ar_size, e_size);
        check("ar_burst", ar_burst, e_burst);
        check("ar_cache", ar_cache, 0);
      end
      ar_pending = ar_valid && !ar_ready;
      if (rd_valid) begin
        check("rd_valid_src", r_valid, 1);
        check("rd_data_pass", rd_data, r_data);
        check("r_ready_mirror", r_ready, rd_ready);
      end
      if (r_ready) check("r_ready_needs_rd_ready", rd_ready, 1);
      if (r_valid && r_ready) begin
        check("beat_expected", exp_data_q.size() != 0, 1);
        if (exp_data_q.size() != 0) begin
          ed = exp_data_q.pop_front();
          el = exp_last_q.pop_front();
          check("rd_data", rd_data, ed);
          check("rd_last", rd_last, el);
          last_rd_data = rd_data;
          delivered++;
          if (exp_data_q.size() == 0) last_beat_cyc = cyc;
        end
      end
      if (done) begin
        check("done_expected", done_pending, 1);
        check("done_beats_left", exp_data_q.size(), 0);
        check("done_timing", cyc, last_beat_cyc + 1);
        check("done_resp", done_resp, m_resp);
        check("done_last_err", done_last_err, m_err);
        done_pending = 0;
      end
      if (done_prev) check("cmd_ready_after_done", cmd_ready, 1);
      done_prev = done;
    end else begin
      done_prev = 0;
    end
  end

  task automatic run_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input int n_sl, input int ar_wait,
                           input bit toggle, input int abort_after, input int lit_beats,
                           input logic [1:0] lit_resp, input bit lit_err);
    int  k, budget;
    bit  hs;
    build_model(l, n_sl);
    e_addr = a; e_len = l; e_size = s; e_burst = b;
    done_pending = 1;
    delivered = 0;
    budget = 0;
    while (!cmd_ready && budget < 20) begin
      @(posedge aclk); #1;
      budget++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b;
    @(posedge aclk); #1;
    cmd_valid = 1'b0; cmd_addr = 32'hDEAD_BEEF; cmd_len = 8'hEE; cmd_size = 3'd7; cmd_burst = 2'd3;
    check("ar_valid_after_accept", ar_valid, 1);
    check("done_resp_held", done_resp, prev_resp);
    check("done_last_err_held", done_last_err, prev_err);
    repeat (ar_wait) begin
      @(posedge aclk); #1;
    end
    ar_ready = 1'b1;
    @(posedge aclk); #1;
    ar_ready = 1'b0;
    check("ar_valid_after_hs", ar_valid, 0);
    k = 0;
    budget = 0;
    while (budget < 200) begin
      if (k < n_sl) begin
        r_valid = 1'b1; r_data = sl_data[k]; r_resp = sl_resp[k]; r_last = sl_last[k];
      end else begin
        r_valid = 1'b0; r_data = '0; r_resp = '0; r_last = 1'b0;
      end
      rd_ready = toggle ? ((budget % 2) == 0) : 1'b1;
      if (abort_after >= 0 && k == abort_after) break;
      #1;
      hs = r_valid && r_ready;
      @(posedge aclk); #1;
      budget++;
      if (hs) k++;
      if (done) break;
    end
    if (abort_after >= 0) begin
      r_valid = 1'b0;
      areset = 1'b1;
      exp_data_q.delete();
      exp_last_q.delete();
      done_pending = 0;
      ar_pending = 0;
      @(posedge aclk); #1;
      areset = 1'b0;
      #1;
      check("rst_r_ready", r_ready, 0);
      check("rst_ar_valid", ar_valid, 0);
      check("rst_done", done, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_ar_addr", ar_addr, 0);
      check("rst_beats_before", delivered, lit_beats);
      prev_resp = 2'd0;
      prev_err  = 1'b0;
      repeat (4) @(posedge aclk);
      #1;
      rd_ready = 1'b0;
    end else begin
      check("done_within_budget", done, 1);
      check("lit_beats", delivered, lit_beats);
      check("lit_resp", done_resp, lit_resp);
      check("lit_err", done_last_err, lit_err);
      prev_resp = lit_resp;
      prev_err  = lit_err;
      r_valid = 1'b0; r_last = 1'b0; r_resp = '0; rd_ready = 1'b0;
      @(posedge aclk); #1;
    end
  endtask

  task automatic fill(input int n, input logic [31:0] base, input int last_idx);
    for (int i = 0; i < 16; i++) begin
      sl_data[i] = base + 32'(i);
      sl_resp[i] = 2'd0;
      sl_last[i] = (i == last_idx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_ar_valid", ar_valid, 0);
    check("reset_ar_addr", ar_addr, 0);
    check("reset_ar_len", ar_len, 0);
    check("reset_r_ready", r_ready, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_last", rd_last, 0);
    check("reset_done", done, 0);
    check("reset_done_resp", done_resp, 0);
    check("reset_done_last_err", done_last_err, 0);
    areset = 1'b0;
    #1;
    check("idle_cmd_ready", cmd_ready, 1);
    chk_en = 1;
    @(posedge aclk); #1;

    // single beat
    fill(16, 32'h0, 0);
    sl_data[0] = 32'hA5A5_A5A5;
    run_burst(32'h100, 8'd0, 3'd2, 2'd1, 1, 0, 0, -1, 1, 2'd0, 1'b0);
    check("lit_single_data", last_rd_data, 32'hA5A5_A5A5);

    // 4 beats, ar_ready delayed 3 cycles, rd_ready toggling
    fill(16, 32'h0, 3);
    run_burst(32'h2000, 8'd3, 3'd2, 2'd1, 4, 3, 1, -1, 4, 2'd0, 1'b0);
    check("lit_4beat_last_data", last_rd_data, 32'h3);

    // response merge: SLVERR on beat 2, EXOKAY on beat 3
    fill(16, 32'h5000, 3);
    sl_resp[1] = 2'd2;
    sl_resp[2] = 2'd1;
    run_burst(32'h3000, 8'd3, 3'd2, 2'd2, 4, 1, 0, -1, 4, 2'd2, 1'b0);

    // early r_last on beat 3 of 8
    fill(16, 32'h7000, 2);
    run_burst(32'h4000, 8'd7, 3'd2, 2'd1, 8, 0, 0, -1, 3, 2'd0, 1'b1);

    // missing r_last on a 2-beat burst; slave keeps offering extra beats
    fill(16, 32'h9000, -1);
    run_burst(32'h5000, 8'd1, 3'd1, 2'd0, 4, 0, 0, -1, 2, 2'd0, 1'b1);

    // reset after 2 of 8 beats
    fill(16, 32'hB000, 7);
    run_burst(32'h6000, 8'd7, 3'd2, 2'd1, 8, 0, 0, 2, 2, 2'd0, 1'b0);

    // normal single beat after reset
    fill(16, 32'hC000, 0);
    sl_resp[0] = 2'd1;
    run_burst(32'h7000, 8'd0, 3'd2, 2'd1, 1, 0, 0, -1, 1, 2'd1, 1'b0);

    repeat (3) @(posedge aclk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
